// File: rtl/operand_fetch_if.sv
// Bundle of instruction, writeback and issue signals between operand_fetch and its neighbours.
interface operand_fetch_if;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        alu_enable;
  logic [15:0] operand_one;
  logic [15:0] operand_two;
  logic [3:0]  opcode;
  logic [3:0]  imm_value;
  logic [3:0]  dest_addr;
  logic        ctrl_req;
  logic [3:0]  ctrl_opcode;
  logic [15:0] ctrl_word;
  logic        exc_div_zero;
  logic        halted;

  modport master (
    output instr_valid, instr, wb_en, wb_addr, wb_data,
    input  instr_ready, alu_enable, operand_one, operand_two, opcode, imm_value,
           dest_addr, ctrl_req, ctrl_opcode, ctrl_word, exc_div_zero, halted
  );

  modport slave (
    input  instr_valid, instr, wb_en, wb_addr, wb_data,
    output instr_ready, alu_enable, operand_one, operand_two, opcode, imm_value,
           dest_addr, ctrl_req, ctrl_opcode, ctrl_word, exc_div_zero, halted
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: register file, pending-write scoreboard, hazard stall/forwarding and
// one-cycle issue of ALU operands or control requests.
module operand_fetch #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  operand_fetch_if.slave   bus
);

  localparam int DATA_W = 16;

  typedef enum logic {S_RUN, S_HALTED} state_t;

  function automatic logic is_ctrl_op(input logic [3:0] op);
    case (op)
      4'h8, 4'h9, 4'hA, 4'hF: is_ctrl_op = 1'b1;
      default:                is_ctrl_op = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rt(input logic [3:0] op);
    case (op)
      4'h0, 4'h2, 4'h4, 4'h6, 4'hB, 4'hC, 4'hE: uses_rt = 1'b1;
      default:                                  uses_rt = 1'b0;
    endcase
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DATA_W-1:0]  r_rf [16];
  logic [15:0]        r_pending;

  logic               r_alu_enable;
  logic [DATA_W-1:0]  r_operand_one;
  logic [DATA_W-1:0]  r_operand_two;
  logic [3:0]         r_opcode;
  logic [3:0]         r_imm_value;
  logic [3:0]         r_dest_addr;
  logic               r_ctrl_req;
  logic [3:0]         r_ctrl_opcode;
  logic [15:0]        r_ctrl_word;
  logic               r_exc_div_zero;

  logic [3:0]         w_op;
  logic [3:0]         w_rd;
  logic [3:0]         w_rs;
  logic [3:0]         w_rt;
  logic               w_is_ctrl;
  logic               w_uses_rt;
  logic [15:0]        w_wb_mask;
  logic [15:0]        w_pend_eff;
  logic               w_fwd_block;
  logic               w_hazard;
  logic               w_ready;
  logic               w_accept;
  logic [DATA_W-1:0]  w_rs_val;
  logic [DATA_W-1:0]  w_rt_val;
  logic               w_div_zero;
  logic               w_issue;
  logic               w_ctrl_acc;
  logic [15:0]        w_pend_nxt;

  assign w_op      = bus.instr[15:12];
  assign w_rd      = bus.instr[11:8];
  assign w_rs      = bus.instr[7:4];
  assign w_rt      = bus.instr[3:0];
  assign w_is_ctrl = is_ctrl_op(w_op);
  assign w_uses_rt = uses_rt(w_op);

  // The writeback clear is applied before the hazard check so a completing write unblocks this cycle.
  assign w_wb_mask  = bus.wb_en ? (16'h0001 << bus.wb_addr) : 16'h0000;
  assign w_pend_eff = r_pending & ~w_wb_mask;

  assign w_fwd_block = !FWD_EN && bus.wb_en &&
                       ((bus.wb_addr == w_rs) || (w_uses_rt && (bus.wb_addr == w_rt)));
  assign w_hazard    = w_pend_eff[w_rs] || (w_uses_rt && w_pend_eff[w_rt]) ||
                       w_pend_eff[w_rd] || w_fwd_block;

  assign w_rs_val = (FWD_EN && bus.wb_en && (bus.wb_addr == w_rs)) ? bus.wb_data : r_rf[w_rs];
  assign w_rt_val = (FWD_EN && bus.wb_en && (bus.wb_addr == w_rt)) ? bus.wb_data : r_rf[w_rt];

  assign w_accept   = bus.instr_valid && w_ready;
  assign w_ctrl_acc = w_accept && w_is_ctrl;
  assign w_div_zero = w_accept && !w_is_ctrl &&
                      (((w_op == 4'h6) && (w_rt_val == '0)) || ((w_op == 4'h7) && (w_rt == 4'h0)));
  assign w_issue    = w_accept && !w_is_ctrl && !w_div_zero;
  assign w_pend_nxt = w_pend_eff | (w_issue ? (16'h0001 << w_rd) : 16'h0000);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    bus.halted  = 1'b0;
    case (r_state)
      S_RUN: begin
        w_ready = w_is_ctrl || !w_hazard;
        if (w_ctrl_acc && (w_op == 4'hF)) w_state_nxt = S_HALTED;
      end
      S_HALTED: bus.halted = 1'b1;
      default:  w_state_nxt = S_RUN;
    endcase
  end

  assign bus.instr_ready = w_ready;

  // Issue stage boundary: everything below is registered toward the ALU / control unit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) r_rf[i] <= '0;
      r_pending      <= '0;
      r_alu_enable   <= 1'b0;
      r_operand_one  <= '0;
      r_operand_two  <= '0;
      r_opcode       <= '0;
      r_imm_value    <= '0;
      r_dest_addr    <= '0;
      r_ctrl_req     <= 1'b0;
      r_ctrl_opcode  <= '0;
      r_ctrl_word    <= '0;
      r_exc_div_zero <= 1'b0;
    end else begin
      if (bus.wb_en) r_rf[bus.wb_addr] <= bus.wb_data;
      r_pending      <= w_pend_nxt;
      r_alu_enable   <= w_issue;
      r_ctrl_req     <= w_ctrl_acc;
      r_exc_div_zero <= w_div_zero;
      if (w_issue) begin
        r_operand_one <= w_rs_val;
        r_operand_two <= w_uses_rt ? w_rt_val : '0;
        r_opcode      <= w_op;
        r_imm_value   <= w_rt;
        r_dest_addr   <= w_rd;
      end
      if (w_ctrl_acc) begin
        r_ctrl_opcode <= w_op;
        r_ctrl_word   <= bus.instr;
      end
    end
  end

  assign bus.alu_enable   = r_alu_enable;
  assign bus.operand_one  = r_operand_one;
  assign bus.operand_two  = r_operand_two;
  assign bus.opcode       = r_opcode;
  assign bus.imm_value    = r_imm_value;
  assign bus.dest_addr    = r_dest_addr;
  assign bus.ctrl_req     = r_ctrl_req;
  assign bus.ctrl_opcode  = r_ctrl_opcode;
  assign bus.ctrl_word    = r_ctrl_word;
  assign bus.exc_div_zero = r_exc_div_zero;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, halt/reset sequences, a no-forwarding
// instance, and randomized traffic checked against a set/array-based reference model.
module tb_operand_fetch;

  logic clk;
  logic reset;

  operand_fetch_if bus();
  operand_fetch_if bus0();

  operand_fetch #(.FWD_EN(1'b1)) dut  (.clk(clk), .reset(reset), .bus(bus));
  operand_fetch #(.FWD_EN(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Opcode sets: bit n set means opcode n belongs to the set.
  localparam logic [15:0] CTRL_SET = 16'h8700;
  localparam logic [15:0] RT_SET   = 16'h5855;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_rf [16];
  logic [15:0] m_pend;
  bit          m_halt;
  bit          e_alu, e_creq, e_exc;
  logic [15:0] e_op1, e_op2, e_cword;
  logic [3:0]  e_opc, e_imm, e_dst, e_copc;

  typedef struct {
    bit r; bit v; logic [15:0] ins; bit we; logic [3:0] wa; logic [15:0] wd;
    bit cr; bit rdy; bit alu; logic [15:0] op1; logic [15:0] op2; logic [3:0] dst;
    bit exc; bit creq; logic [3:0] copc; logic [15:0] cword; bit hlt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit r, bit v, logic [15:0] ins, bit we, logic [3:0] wa,
                              logic [15:0] wd, bit cr, bit rdy, bit alu, logic [15:0] op1,
                              logic [15:0] op2, logic [3:0] dst, bit exc, bit creq,
                              logic [3:0] copc, logic [15:0] cword, bit hlt);
    vec_t t;
    t.r = r; t.v = v; t.ins = ins; t.we = we; t.wa = wa; t.wd = wd;
    t.cr = cr; t.rdy = rdy; t.alu = alu; t.op1 = op1; t.op2 = op2; t.dst = dst;
    t.exc = exc; t.creq = creq; t.copc = copc; t.cword = cword; t.hlt = hlt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] rdval(input logic [3:0] s, input bit we,
                                        input logic [3:0] wa, input logic [15:0] wd);
    return (we && wa == s) ? wd : m_rf[s];
  endfunction

  task automatic cycle(input bit r, input bit v, input logic [15:0] ins, input bit we,
                       input logic [3:0] wa, input logic [15:0] wd, output logic rdy_s);
    logic [15:0] pa;
    logic [15:0] vrs, vrt;
    logic [3:0]  op, rd, rs, rt;
    bit          haz, rdy, isc, urt;
    int          srcs[$];
    @(negedge clk);
    reset = r; bus.instr_valid = v; bus.instr = ins;
    bus.wb_en = we; bus.wb_addr = wa; bus.wb_data = wd;
    #1;
    rdy_s = bus.instr_ready;
    op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
    isc = CTRL_SET[op];
    urt = RT_SET[op];
    pa = m_pend;
    if (we) pa[wa] = 1'b0;
    srcs.push_back(int'(rs));
    if (urt) srcs.push_back(int'(rt));
    haz = pa[rd];
    foreach (srcs[i]) if (pa[srcs[i]]) haz = 1'b1;
    rdy = !m_halt && (isc || !haz);
    if (!r) chk("instr_ready", rdy_s, rdy);
    vrs = rdval(rs, we, wa, wd);
    vrt = rdval(rt, we, wa, wd);
    e_alu = 0; e_creq = 0; e_exc = 0;
    if (r) begin
      foreach (m_rf[i]) m_rf[i] = '0;
      m_pend = '0; m_halt = 0;
      e_op1 = '0; e_op2 = '0; e_opc = '0; e_imm = '0; e_dst = '0; e_copc = '0; e_cword = '0;
    end else begin
      if (v && rdy) begin
        if (isc) begin
          e_creq = 1; e_copc = op; e_cword = ins;
          if (op == 4'hF) m_halt = 1;
        end else if ((op == 4'h6 && vrt == 0) || (op == 4'h7 && rt == 0)) begin
          e_exc = 1;
        end else begin
          e_alu = 1; e_op1 = vrs; e_op2 = urt ? vrt : 16'h0;
          e_opc = op; e_imm = rt; e_dst = rd;
          pa[rd] = 1'b1;
        end
      end
      if (we) m_rf[wa] = wd;
      m_pend = pa;
    end
    @(posedge clk);
    #1;
    chk("alu_enable", bus.alu_enable, e_alu);
    chk("operand_one", bus.operand_one, e_op1);
    chk("operand_two", bus.operand_two, e_op2);
    chk("opcode", bus.opcode, e_opc);
    chk("imm_value", bus.imm_value, e_imm);
    chk("dest_addr", bus.dest_addr, e_dst);
    chk("ctrl_req", bus.ctrl_req, e_creq);
    chk("ctrl_opcode", bus.ctrl_opcode, e_copc);
    chk("ctrl_word", bus.ctrl_word, e_cword);
    chk("exc_div_zero", bus.exc_div_zero, e_exc);
    chk("halted", bus.halted, m_halt);
    chk("pending", dut.r_pending, m_pend);
    chk("rf_rs", dut.r_rf[rs], m_rf[rs]);
  endtask

  initial begin
    logic rs_;
    logic [15:0] ins;
    logic [3:0]  op, wa;
    bit          we, rr;
    reset = 1'b0;
    bus.instr_valid = 0; bus.instr = '0; bus.wb_en = 0; bus.wb_addr = '0; bus.wb_data = '0;
    bus0.instr_valid = 0; bus0.instr = '0; bus0.wb_en = 0; bus0.wb_addr = '0; bus0.wb_data = '0;
    foreach (m_rf[i]) m_rf[i] = '0;
    m_pend = '0; m_halt = 0;

    //        r v ins       we wa wd     cr rdy alu op1 op2 dst exc creq copc cword    hlt
    vq.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 0, 16'h0000, 1, 2, 16'h3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 1, 16'h0312, 0, 0, 16'h0, 1, 1, 1, 5, 3, 3, 0, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 1, 16'h4431, 0, 0, 16'h0, 1, 0, 0, 5, 3, 3, 0, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 1, 16'h4431, 1, 3, 16'h8, 1, 1, 1, 8, 5, 4, 0, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 0, 16'h0000, 1, 2, 16'h0, 1, 1, 0, 8, 5, 4, 0, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 1, 16'h6512, 0, 0, 16'h0, 1, 1, 0, 8, 5, 4, 1, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 1, 16'h7510, 0, 0, 16'h0, 1, 1, 0, 8, 5, 4, 1, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0, 1, 1, 0, 8, 5, 4, 0, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 1, 16'h9ABC, 0, 0, 16'h0, 1, 1, 0, 8, 5, 4, 0, 1, 9, 16'h9ABC, 0));
    vq.push_back(mk(0, 1, 16'hF000, 0, 0, 16'h0, 1, 1, 0, 8, 5, 4, 0, 1, 15, 16'hF000, 1));

    foreach (vq[i]) begin
      cycle(vq[i].r, vq[i].v, vq[i].ins, vq[i].we, vq[i].wa, vq[i].wd, rs_);
      if (vq[i].cr) chk($sformatf("t%0d_ready", i), rs_, vq[i].rdy);
      chk($sformatf("t%0d_alu", i), bus.alu_enable, vq[i].alu);
      chk($sformatf("t%0d_op1", i), bus.operand_one, vq[i].op1);
      chk($sformatf("t%0d_op2", i), bus.operand_two, vq[i].op2);
      chk($sformatf("t%0d_dst", i), bus.dest_addr, vq[i].dst);
      chk($sformatf("t%0d_exc", i), bus.exc_div_zero, vq[i].exc);
      chk($sformatf("t%0d_creq", i), bus.ctrl_req, vq[i].creq);
      chk($sformatf("t%0d_copc", i), bus.ctrl_opcode, vq[i].copc);
      chk($sformatf("t%0d_cword", i), bus.ctrl_word, vq[i].cword);
      chk($sformatf("t%0d_halted", i), bus.halted, vq[i].hlt);
    end
    chk("pend5_after_div", dut.r_pending[5], 1'b0);

    // Halted with a waiting instruction: no acceptance for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      cycle(0, 1, 16'hF000, 0, 0, 16'h0, rs_);
      chk("halt_ready", rs_, 1'b0);
      chk("halt_flag", bus.halted, 1'b1);
      chk("halt_creq", bus.ctrl_req, 1'b0);
    end
    cycle(0, 1, 16'h0312, 1, 1, 16'h5, rs_);
    chk("halt_wb_r1", dut.r_rf[1], 16'h5);
    // Reset beats a simultaneous writeback and instruction.
    cycle(1, 1, 16'h0312, 1, 1, 16'h7, rs_);
    chk("rst_halted", bus.halted, 1'b0);
    chk("rst_r1", dut.r_rf[1], 16'h0);
    chk("rst_pending", dut.r_pending, 16'h0);
    chk("rst_alu", bus.alu_enable, 1'b0);
    cycle(0, 0, 16'h0000, 0, 0, 16'h0, rs_);
    chk("rst_ready", rs_, 1'b1);

    // No-forwarding instance: a source being written this cycle stalls, then reads the new value.
    bus0.wb_en = 1; bus0.wb_addr = 4'd1; bus0.wb_data = 16'h0055;
    bus0.instr_valid = 1; bus0.instr = 16'h0312;
    #1;
    chk("nofwd_stall", bus0.instr_ready, 1'b0);
    cycle(0, 0, 16'h0000, 0, 0, 16'h0, rs_);
    chk("nofwd_held", bus0.alu_enable, 1'b0);
    bus0.wb_en = 0;
    #1;
    chk("nofwd_ready", bus0.instr_ready, 1'b1);
    cycle(0, 0, 16'h0000, 0, 0, 16'h0, rs_);
    chk("nofwd_alu", bus0.alu_enable, 1'b1);
    chk("nofwd_op1", bus0.operand_one, 16'h0055);
    bus0.instr_valid = 0;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 4000; n++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h9;
      ins = {op, 12'($urandom)};
      we = ($urandom_range(0, 1) == 1);
      wa = 4'($urandom);
      if (m_pend != 0 && $urandom_range(0, 2) != 0)
        for (int t = 0; t < 16; t++) begin
          wa = 4'($urandom);
          if (m_pend[wa]) break;
        end
      rr = (m_halt && $urandom_range(0, 4) == 0) || ($urandom_range(0, 99) == 0);
      cycle(rr, ($urandom_range(0, 3) != 0), ins, we, wa,
            ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom), rs_);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
